hier_fanout_pipe: RTL

Parametrised hierarchical fanout pipeline used as a resizer buffer-insertion test vehicle. A top-level driver register broadcasts one data word to `CHANNELS` instances of a sink sub-module and to a top-level load register. Inside each sink an internal net deliberately carries the same name as the top-level broadcast net, so port punching must avoid the name collision. This is the multi-channel, clocked, flow-controlled generalisation of the single-driver hierarchical collision case, with valid/ready handshaking and configurable depth.

---
 rtl/hier_fanout_pipe_pkg.sv | 26 ++
 rtl/hier_fanout_pipe_if.sv | 28 ++
 rtl/hier_fanout_pipe_sink.sv | 59 +++++
 rtl/hier_fanout_pipe.sv | 74 +++++++
 4 files changed

// File: rtl/hier_fanout_pipe_pkg.sv
// Shared constants and the lane rotation helper for hier_fanout_pipe.
// Supports word widths up to MAX_W bits.
package hier_fanout_pkg;

   localparam int CNT_W = 16;
   localparam int MAX_W = 64;

   // Rotate the low `width` bits of `word` left by `amount`. An amount equal to width is the identity.
   function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] word,
                                             input int unsigned    amount,
                                             input int unsigned    width);
      logic [MAX_W-1:0] res;
      logic [5:0]       src;
      logic [5:0]       dst;
      res = '0;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if (i < width) begin
            src      = 6'(i);
            dst      = 6'((i + amount) % width);
            res[dst] = word[src];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/hier_fanout_pipe_if.sv
// Handshake and output bundle of hier_fanout_pipe. The master side drives words in and
// accepts bundles; the slave side is the pipeline itself.
interface hier_fanout_pipe_if
   import hier_fanout_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
);
   logic                      in_valid;
   logic                      in_ready;
   logic [WIDTH-1:0]          in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [CHANNELS*WIDTH-1:0] out_data;
   logic [CHANNELS-1:0]       out_parity;
   logic [WIDTH-1:0]          out_mirror;
   logic [CNT_W-1:0]          beat_count;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_parity, out_mirror, beat_count
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_parity, out_mirror, beat_count
   );
endinterface

// File: rtl/hier_fanout_pipe_sink.sv
// fanout_sink: one lane of the broadcast fanout. It mixes the incoming word with a
// lane-specific rotation of itself, takes the word parity, and delays both DEPTH stages.
module fanout_sink
   import hier_fanout_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int LANE  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             v_in,
   input  logic [WIDTH-1:0] A,
   output logic             v_out,
   output logic [WIDTH-1:0] lane,
   output logic             parity
);
   // Deliberately shares its name with the parent's broadcast register.
   logic [WIDTH-1:0] bcast;
   logic [MAX_W-1:0] rot;

   logic             v_q [DEPTH];
   logic [WIDTH-1:0] x_q [DEPTH];
   logic             p_q [DEPTH];

   // NOTE: always_comb assigns every output before any condition, so no latch can be inferred.
   always_comb begin
      rot   = rotl(MAX_W'(A), LANE + 1, WIDTH);
      bcast = A ^ rot[WIDTH-1:0];
   end

   // Parity comes straight from the port: the mixed word always has even parity.
   // NOTE: state uses non-blocking assignments so every stage samples its predecessor's old value.
   // NOTE: the stage arrays are pipeline registers, not RAM, so they take the async reset like any flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            v_q[i] <= 1'b0;
            x_q[i] <= '0;
            p_q[i] <= 1'b0;
         end
      end else if (en) begin
         v_q[0] <= v_in;
         x_q[0] <= bcast;
         p_q[0] <= ^A;
         for (int i = 1; i < DEPTH; i++) begin
            v_q[i] <= v_q[i-1];
            x_q[i] <= x_q[i-1];
            p_q[i] <= p_q[i-1];
         end
      end
   end

   assign v_out  = v_q[DEPTH-1];
   assign lane   = x_q[DEPTH-1];
   assign parity = p_q[DEPTH-1];

endmodule

// File: rtl/hier_fanout_pipe.sv
// hier_fanout_pipe: a driver register broadcasts each accepted word to CHANNELS sinks
// and to an aligned mirror chain; the whole pipeline stalls together under backpressure.
module hier_fanout_pipe
   import hier_fanout_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int DEPTH    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   hier_fanout_pipe_if.slave   bus
);
   logic                      adv;
   logic                      accept;
   logic                      out_valid;
   logic                      v0;
   logic [WIDTH-1:0]          bcast;
   logic [WIDTH-1:0]          mirror_q [DEPTH];
   logic [CNT_W-1:0]          beat_q;
   logic [CHANNELS-1:0]       sink_v;
   logic [CHANNELS*WIDTH-1:0] lanes;
   logic [CHANNELS-1:0]       parity;

   // A single enable for every stage keeps all lanes and the mirror in lockstep.
   assign adv    = !out_valid || bus.out_ready;
   assign accept = bus.in_valid && adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0     <= 1'b0;
         bcast  <= '0;
         beat_q <= '0;
         for (int i = 0; i < DEPTH; i++) mirror_q[i] <= '0;
      end else begin
         if (adv) begin
            v0 <= accept;
            if (accept) bcast <= bus.in_data;
            mirror_q[0] <= bcast;
            for (int i = 1; i < DEPTH; i++) mirror_q[i] <= mirror_q[i-1];
         end
         if (out_valid && bus.out_ready) beat_q <= beat_q + CNT_W'(1);
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      fanout_sink #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .LANE  (c)
      ) u_sink (
         .clk    (clk),
         .rst_n  (rst_n),
         .en     (adv),
         .v_in   (v0),
         .A      (bcast),
         .v_out  (sink_v[c]),
         .lane   (lanes[c*WIDTH +: WIDTH]),
         .parity (parity[c])
      );
   end

   a_lanes_in_step: assert property (@(posedge clk) disable iff (!rst_n)
      sink_v == {CHANNELS{sink_v[0]}});

   assign out_valid      = sink_v[0];
   assign bus.out_valid  = out_valid;
   assign bus.in_ready   = adv;
   assign bus.out_data   = lanes;
   assign bus.out_parity = parity;
   assign bus.out_mirror = mirror_q[DEPTH-1];
   assign bus.beat_count = beat_q;

endmodule
